// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: datapath width, canonical NOP encoding and
// a helper for sizing the occupancy counters.
package fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0000;

    // Counters must represent 0..DEPTH inclusive, hence one bit above the pointer width.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of {pc, inst, filled} entries. Slots are allocated at issue time
// and filled in order as responses return; the head can be bypassed from the fill data.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = cnt_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_data,
    input  logic            pop,
    input  logic            flush,
    output logic            head_ready,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_inst,
    output logic [CW-1:0]   alloc_cnt,
    output logic [CW-1:0]   unfilled_cnt
);
    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [XLEN-1:0]  inst_mem [DEPTH];
    logic [DEPTH-1:0] filled_reg;
    logic [DEPTH-1:0] alloc_hit;
    logic [DEPTH-1:0] fill_hit;
    logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg, fill_ptr_reg;
    logic [CW-1:0]    alloc_cnt_reg, unfilled_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign alloc_hit[gi] = alloc && !flush && (wr_ptr_reg == PW'(gi));
            assign fill_hit[gi]  = fill && !flush && (fill_ptr_reg == PW'(gi));
        end
    endgenerate

    // Allocation clears the filled bit, so flushed entries never need scrubbing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filled_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_hit[i]) begin
                    pc_mem[i]     <= alloc_pc;
                    filled_reg[i] <= 1'b0;
                end else if (fill_hit[i]) begin
                    inst_mem[i]   <= fill_data;
                    filled_reg[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            fill_ptr_reg     <= '0;
            alloc_cnt_reg    <= '0;
            unfilled_cnt_reg <= '0;
        end else if (flush) begin
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            fill_ptr_reg     <= '0;
            alloc_cnt_reg    <= '0;
            unfilled_cnt_reg <= '0;
        end else begin
            rd_ptr_reg       <= rd_ptr_reg + PW'(pop);
            wr_ptr_reg       <= wr_ptr_reg + PW'(alloc);
            fill_ptr_reg     <= fill_ptr_reg + PW'(fill);
            alloc_cnt_reg    <= alloc_cnt_reg + CW'(alloc) - CW'(pop);
            unfilled_cnt_reg <= unfilled_cnt_reg + CW'(alloc) - CW'(fill);
        end
    end

    // Fills land in order, so an unfilled head is always the slot the fill targets.
    assign head_ready   = (alloc_cnt_reg != '0) && (filled_reg[rd_ptr_reg] || fill);
    assign head_pc      = pc_mem[rd_ptr_reg];
    assign head_inst    = filled_reg[rd_ptr_reg] ? inst_mem[rd_ptr_reg] : fill_data;
    assign alloc_cnt    = alloc_cnt_reg;
    assign unfilled_cnt = unfilled_cnt_reg;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues npc to instruction memory, buffers in-order responses and
// presents the head to DECODE; a late branch flushes and drops in-flight responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] NOP_INST = NOP_ENC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] npc,
    input  logic            br_late,
    output logic            fetch_stall,
    output logic [XLEN-1:0] inst_feedback,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_inst
);
    localparam int CW = cnt_width(DEPTH);

    logic            issue, fill, pop, head_ready, resp_consumed;
    logic [XLEN-1:0] head_pc, head_inst;
    logic [CW-1:0]   alloc_cnt, unfilled_cnt, drop_cnt_reg, drop_cnt_next;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk          (clk),
        .rst          (rst),
        .alloc        (issue),
        .alloc_pc     (npc),
        .fill         (fill),
        .fill_data    (imem_resp_data),
        .pop          (pop),
        .flush        (br_late),
        .head_ready   (head_ready),
        .head_pc      (head_pc),
        .head_inst    (head_inst),
        .alloc_cnt    (alloc_cnt),
        .unfilled_cnt (unfilled_cnt)
    );

    // Gated by rst so the request port is idle while reset is held.
    assign imem_req_valid = rst && !br_late && (alloc_cnt < CW'(DEPTH));
    assign imem_req_addr  = npc;
    assign issue          = imem_req_valid && imem_req_ready;
    assign fetch_stall    = !issue;

    assign fill          = imem_resp_valid && (drop_cnt_reg == '0) && !br_late;
    assign dec_valid     = head_ready && !br_late;
    assign pop           = dec_valid && dec_ready;
    assign dec_inst      = dec_valid ? head_inst : NOP_INST;
    assign dec_pc        = head_pc;
    assign inst_feedback = dec_inst;

    // A response is retired against drop_cnt when dropping, or against the flushed unfilled slots.
    assign resp_consumed = imem_resp_valid && ((drop_cnt_reg != '0) || br_late);
    assign drop_cnt_next = drop_cnt_reg + (br_late ? unfilled_cnt : '0) - CW'(resp_consumed);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_reg <= '0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    a_resp_expected: assert property (@(posedge clk) disable iff (!rst)
        (imem_resp_valid && (drop_cnt_reg == '0)) |-> (unfilled_cnt != '0));
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst)
        drop_cnt_reg <= CW'(DEPTH));
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: the bench plays instruction memory and checks the
// DUT each cycle against a queue-based model of the fetch buffer and drop accounting.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] npc = '0;
    logic        br_late = 1'b0;
    logic        fetch_stall;
    logic [31:0] inst_feedback;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .npc             (npc),
        .br_late         (br_late),
        .fetch_stall     (fetch_stall),
        .inst_feedback   (inst_feedback),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_pc          (dec_pc),
        .dec_inst        (dec_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ent_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    ent_t        q[$];
    rsp_t        mem[$];
    logic [31:0] popped[$];
    int          drop = 0;
    int          cyc = 0;
    int          last_due = -1;
    int          seq = 0;
    int          checks = 0;
    int          errors = 0;
    bit          issued;
    logic [31:0] pcv;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check_eq({tag, "_stall"}, 32'(fetch_stall), 32'd1);
        check_eq({tag, "_dec_valid"}, 32'(dec_valid), 32'd0);
        check_eq({tag, "_dec_inst"}, dec_inst, NOP_ENC);
        check_eq({tag, "_drop_cnt"}, 32'(dut.drop_cnt_reg), 32'd0);
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic step(input logic [31:0] n, input bit bl, input bit rdy, input bit drdy, input int lat);
        bit          resp, exp_rv, fill_now, hr, dv;
        int          fidx, unf, due;
        logic [31:0] exp_inst;
        ent_t        e;
        rsp_t        r;
        @(negedge clk);
        npc             = n;
        br_late         = bl;
        imem_req_ready  = rdy;
        dec_ready       = drdy;
        resp            = (mem.size() > 0) && (mem[0].due == cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem[0].data : $urandom;
        #1;
        exp_rv   = !bl && (q.size() < DEPTH);
        issued   = exp_rv && rdy;
        fill_now = resp && (drop == 0) && !bl;
        fidx     = -1;
        for (int i = q.size() - 1; i >= 0; i--) if (!q[i].filled) fidx = i;
        hr       = (q.size() > 0) && (q[0].filled || (fill_now && fidx == 0));
        dv       = hr && !bl;
        exp_inst = dv ? (q[0].filled ? q[0].inst : imem_resp_data) : NOP_ENC;

        check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        check_eq("fetch_stall", 32'(fetch_stall), 32'(!issued));
        check_eq("req_addr", imem_req_addr, n);
        check_eq("dec_valid", 32'(dec_valid), 32'(dv));
        check_eq("dec_inst", dec_inst, exp_inst);
        check_eq("inst_feedback", inst_feedback, exp_inst);
        check_eq("drop_cnt", 32'(dut.drop_cnt_reg), 32'(drop));
        if (dv) check_eq("dec_pc", dec_pc, q[0].pc);

        if (bl) begin
            unf = 0;
            foreach (q[i]) if (!q[i].filled) unf++;
            drop = drop + unf - (resp ? 1 : 0);
            q.delete();
        end else begin
            if (resp) begin
                if (drop > 0) drop--;
                else if (fidx >= 0) begin
                    e = q[fidx];
                    e.inst = imem_resp_data;
                    e.filled = 1'b1;
                    q[fidx] = e;
                end
            end
            if (dv && drdy) begin
                $display("dec cycle=%0d pc=%h inst=%h", cyc, q[0].pc, q[0].inst);
                popped.push_back(q[0].pc);
                void'(q.pop_front());
            end
            if (issued) begin
                e.pc = n;
                e.inst = '0;
                e.filled = 1'b0;
                q.push_back(e);
            end
        end
        if (resp) void'(mem.pop_front());
        if (issued) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            r.due = due;
            r.data = (n * 32'h9E37_79B1) ^ 32'(seq);
            seq++;
            mem.push_back(r);
            last_due = due;
        end
        cyc++;
    endtask

    // Issue-following stream: pc advances by 4 whenever a request is accepted.
    task automatic run(input int cycles, input bit rdy, input bit drdy, input int lat);
        for (int i = 0; i < cycles; i++) begin
            step(pcv, 1'b0, rdy, drdy, lat);
            if (issued) pcv += 4;
        end
    endtask

    task automatic drain();
        run(8, 1'b0, 1'b1, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        q.delete();
        mem.delete();
        drop = 0;
        last_due = -1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        br_late         = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int hold_accepts;
        #1;
        check_reset_outputs("rst_init");
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait memory, sequential stream from 0
        pcv = 32'h0;
        run(8, 1'b1, 1'b1, 1);
        check_eq("s1_first_pc", popped[0], 32'h0);
        check_eq("s1_third_pc", popped[2], 32'h8);

        // DECODE stalled: exactly DEPTH accepts, then drains in order
        drain();
        hold_accepts = 0;
        for (int i = 0; i < 8; i++) begin
            step(pcv, 1'b0, 1'b1, 1'b0, 1);
            if (issued) begin
                pcv += 4;
                hold_accepts++;
            end
        end
        check_eq("s2_hold_accepts", 32'(hold_accepts), 32'(DEPTH));
        run(12, 1'b1, 1'b1, 1);

        // Flush with two requests outstanding at latency 3
        drain();
        run(2, 1'b1, 1'b1, 3);
        step(32'hDEAD_0000, 1'b1, 1'b1, 1'b1, 3);
        popped.delete();
        pcv = 32'h100;
        run(10, 1'b1, 1'b1, 3);
        check_eq("s3_target_pc", popped[0], 32'h100);

        // Flush colliding with a response and a would-be pop
        run(6, 1'b1, 1'b1, 2);
        step(32'hBEEF_0000, 1'b1, 1'b1, 1'b1, 2);
        pcv = 32'h200;
        run(8, 1'b1, 1'b1, 2);

        // Request-ready toggling
        for (int i = 0; i < 10; i++) begin
            step(pcv, 1'b0, (i % 2) == 0, 1'b1, 1);
            if (issued) pcv += 4;
        end

        // Reset with the queue full
        drain();
        run(6, 1'b1, 1'b0, 1);
        do_reset();
        pcv = 32'h2000;
        run(6, 1'b1, 1'b1, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                step($urandom, 1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(1, 3));
                pcv = {$urandom_range(0, 65535), 2'b00};
            end else begin
                step(pcv, 1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(1, 3));
                if (issued) pcv += 4;
            end
            if (i == 1500) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
